// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - MIPS memory opcode constants
//   - FSM state encoding and access-size encoding
//   - helpers deriving lane count and byte-offset width from the data width
package mem_lsu_pkg;

    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SW  = 6'h2B;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Width of one memory access; SZ_WORD means the full DATA_W.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int lane_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory port between the load/store unit and memory.
//   mem_ce    request active (held for the whole access)
//   mem_wr    1 = write, 0 = read
//   mem_addr  lane-aligned address
//   mem_be    byte enables
//   mem_wdata lane-replicated store data
//   mem_rdata read data, valid while mem_ready = 1
//   mem_ready access completes this cycle
// Handshake: a request is outstanding from the cycle mem_ce rises until the
// first cycle in which mem_ready is 1; request fields are stable throughout,
// and mem_ready while mem_ce is low carries no meaning.
interface mem_lsu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    logic                  mem_ce;
    logic                  mem_wr;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ready;

    modport master (
        output mem_ce, mem_wr, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_ce, mem_wr, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_lsu_lane.sv
// Combinational lane logic for one access.
//   size, sext : access width and sign-extension flag
//   offset     : byte offset within the memory word
//   data_in    : store data (store path) or memory read data (load path)
//   be         : byte enables for the access
//   data_out   : LOAD=0 -> store data replicated across lanes
//                LOAD=1 -> selected lane, sign- or zero-extended
module mem_lsu_lane
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter bit LOAD   = 1'b0
) (
    input  size_t                            size,
    input  logic                             sext,
    input  logic [lane_off_w(DATA_W)-1:0]    offset,
    input  logic [DATA_W-1:0]                data_in,
    output logic [lane_count(DATA_W)-1:0]    be,
    output logic [DATA_W-1:0]                data_out
);
    localparam int LANES = lane_count(DATA_W);
    localparam int OFF_W = lane_off_w(DATA_W);

    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] ext;
    logic [DATA_W-1:0] rep;

    // Halfwords are selected by the offset with bit 0 ignored, so the
    // part-select never runs past the top lane.
    assign byte_v = data_in[{offset, 3'b000} +: 8];
    assign half_v = data_in[{offset[OFF_W-1:1], 4'b0000} +: 16];

    always_comb begin
        be  = '1;
        ext = data_in;
        rep = data_in;
        case (size)
            SZ_BYTE: begin
                be  = LANES'(1) << offset;
                ext = {{(DATA_W-8){sext & byte_v[7]}}, byte_v};
                rep = {(DATA_W/8){data_in[7:0]}};
            end
            SZ_HALF: begin
                be  = LANES'(3) << {offset[OFF_W-1:1], 1'b0};
                ext = {{(DATA_W-16){sext & half_v[15]}}, half_v};
                rep = {(DATA_W/16){data_in[15:0]}};
            end
            default: begin
                be  = '1;
                ext = data_in;
                rep = data_in;
            end
        endcase
    end

    assign data_out = LOAD ? ext : rep;

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit.
//   clk, rst          clock; asynchronous active-low reset
//   valid_i, op_i     EX result valid and MIPS opcode
//   addr_i, wdata_i   effective address and store data
//   alu_data_i        result for non-memory ops
//   rd_addr_i, rd_wr_i destination register and write enable
//   stall_o           combinational hold for upstream stages
//   mem               data-memory port (master side)
//   reg_wr/addr/data  registered RegFile writeback
//   align_err         one-cycle pulse: misaligned access dropped
//   timeout_err       one-cycle pulse: access abandoned after MAX_WAIT
//   state_dbg         current FSM state
// Upstream valid/ready: the op on the inputs is consumed at the first rising
// edge where stall_o is 0; upstream keeps it stable while stall_o is 1.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 6,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [OP_W-1:0]       op_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W-1:0]     alu_data_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  rd_wr_i,
    output logic                  stall_o,
    mem_lsu_if.master             mem,
    output logic                  reg_wr,
    output logic [REG_ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0]     reg_data,
    output logic                  align_err,
    output logic                  timeout_err,
    output state_t                state_dbg
);
    localparam int LANES = lane_count(DATA_W);
    localparam int OFF_W = lane_off_w(DATA_W);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    // ---------------- opcode decode ----------------
    function automatic logic op_is_load(input logic [OP_W-1:0] op);
        return (op == OP_W'(LB)) || (op == OP_W'(LH)) || (op == OP_W'(LW)) ||
               (op == OP_W'(LBU)) || (op == OP_W'(LHU));
    endfunction

    function automatic logic op_is_store(input logic [OP_W-1:0] op);
        return (op == OP_W'(SB)) || (op == OP_W'(SH)) || (op == OP_W'(SW));
    endfunction

    function automatic size_t op_size(input logic [OP_W-1:0] op);
        if ((op == OP_W'(LB)) || (op == OP_W'(LBU)) || (op == OP_W'(SB)))
            return SZ_BYTE;
        else if ((op == OP_W'(LH)) || (op == OP_W'(LHU)) || (op == OP_W'(SH)))
            return SZ_HALF;
        else
            return SZ_WORD;
    endfunction

    function automatic logic op_signed(input logic [OP_W-1:0] op);
        return (op == OP_W'(LB)) || (op == OP_W'(LH));
    endfunction

    // ---------------- state ----------------
    state_t                  state, state_n;
    logic [CNT_W-1:0]        wait_cnt, wait_cnt_n;
    logic                    ce_q, ce_n;
    logic                    wr_q, wr_n;
    logic [ADDR_W-1:0]       addr_q, addr_n;
    logic [LANES-1:0]        be_q, be_n;
    logic [DATA_W-1:0]       wdata_q, wdata_n;
    logic [OP_W-1:0]         op_q, op_n;
    logic [OFF_W-1:0]        off_q, off_n;
    logic [REG_ADDR_W-1:0]   rd_q, rd_n;
    logic                    rd_wr_q, rd_wr_n;
    logic                    reg_wr_n;
    logic [REG_ADDR_W-1:0]   reg_addr_n;
    logic [DATA_W-1:0]       reg_data_n;
    logic                    align_n;
    logic                    timeout_n;
    logic                    stall;

    // ---------------- lane logic ----------------
    size_t             st_size, ld_size;
    logic              st_sext, ld_sext;
    logic [LANES-1:0]  st_be, ld_be;
    logic [DATA_W-1:0] st_data, ld_data;

    assign st_size = op_size(op_i);
    assign st_sext = op_signed(op_i);
    assign ld_size = op_size(op_q);
    assign ld_sext = op_signed(op_q);

    mem_lsu_lane #(.DATA_W(DATA_W), .LOAD(1'b0)) u_store_lane (
        .size     (st_size),
        .sext     (st_sext),
        .offset   (addr_i[OFF_W-1:0]),
        .data_in  (wdata_i),
        .be       (st_be),
        .data_out (st_data)
    );

    // Its byte enables duplicate the registered mem_be and are not needed.
    mem_lsu_lane #(.DATA_W(DATA_W), .LOAD(1'b1)) u_load_lane (
        .size     (ld_size),
        .sext     (ld_sext),
        .offset   (off_q),
        .data_in  (mem.mem_rdata),
        .be       (ld_be),
        .data_out (ld_data)
    );

    // ---------------- issue-side decode ----------------
    logic is_mem_i;
    logic misalign_i;

    assign is_mem_i   = valid_i && (op_is_load(op_i) || op_is_store(op_i));
    assign misalign_i = ((st_size == SZ_HALF) && addr_i[0]) ||
                        ((st_size == SZ_WORD) && (addr_i[OFF_W-1:0] != '0));

    // ---------------- next state / outputs ----------------
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        ce_n       = ce_q;
        wr_n       = wr_q;
        addr_n     = addr_q;
        be_n       = be_q;
        wdata_n    = wdata_q;
        op_n       = op_q;
        off_n      = off_q;
        rd_n       = rd_q;
        rd_wr_n    = rd_wr_q;
        reg_wr_n   = 1'b0;
        reg_addr_n = reg_addr;
        reg_data_n = reg_data;
        align_n    = 1'b0;
        timeout_n  = 1'b0;
        stall      = 1'b0;

        case (state)
            IDLE: begin
                if (is_mem_i) begin
                    if (misalign_i) begin
                        align_n = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        state_n    = ACCESS;
                        wait_cnt_n = '0;
                        ce_n       = 1'b1;
                        wr_n       = op_is_store(op_i);
                        addr_n     = {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        be_n       = st_be;
                        wdata_n    = st_data;
                        op_n       = op_i;
                        off_n      = addr_i[OFF_W-1:0];
                        rd_n       = rd_addr_i;
                        rd_wr_n    = rd_wr_i;
                    end
                end else begin
                    reg_wr_n   = valid_i && rd_wr_i && (rd_addr_i != '0);
                    reg_addr_n = rd_addr_i;
                    reg_data_n = alu_data_i;
                end
            end

            ACCESS: begin
                if (mem.mem_ready) begin
                    state_n    = IDLE;
                    ce_n       = 1'b0;
                    wait_cnt_n = '0;
                    if (!wr_q) begin
                        reg_wr_n   = rd_wr_q && (rd_q != '0);
                        reg_addr_n = rd_q;
                        reg_data_n = ld_data;
                    end
                end else if (wait_cnt == CNT_W'(MAX_WAIT)) begin
                    // The access is abandoned this cycle, so upstream is
                    // released now rather than re-presenting the same op.
                    state_n    = IDLE;
                    ce_n       = 1'b0;
                    wait_cnt_n = '0;
                    timeout_n  = 1'b1;
                end else begin
                    stall      = 1'b1;
                    wait_cnt_n = wait_cnt + CNT_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
                ce_n    = 1'b0;
            end
        endcase
    end

    // Stall is forced low while reset is asserted, like every other output.
    assign stall_o   = stall & rst;
    assign state_dbg = state;

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            ce_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            op_q        <= '0;
            off_q       <= '0;
            rd_q        <= '0;
            rd_wr_q     <= 1'b0;
            reg_wr      <= 1'b0;
            reg_addr    <= '0;
            reg_data    <= '0;
            align_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            wait_cnt    <= wait_cnt_n;
            ce_q        <= ce_n;
            wr_q        <= wr_n;
            addr_q      <= addr_n;
            be_q        <= be_n;
            wdata_q     <= wdata_n;
            op_q        <= op_n;
            off_q       <= off_n;
            rd_q        <= rd_n;
            rd_wr_q     <= rd_wr_n;
            reg_wr      <= reg_wr_n;
            reg_addr    <= reg_addr_n;
            reg_data    <= reg_data_n;
            align_err   <= align_n;
            timeout_err <= timeout_n;
        end
    end

    assign mem.mem_ce    = ce_q;
    assign mem.mem_wr    = wr_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic        valid_i = 1'b0;
  logic [5:0]  op_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] alu_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        rd_wr_i = 1'b0;
  logic        stall_o;
  logic        reg_wr;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic        align_err;
  logic        timeout_err;
  state_t      state_dbg;

  mem_lsu_if #(.DATA_W(32), .ADDR_W(32)) mem_bus ();

  mem_lsu #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5), .OP_W(6), .MAX_WAIT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .op_i        (op_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .alu_data_i  (alu_data_i),
    .rd_addr_i   (rd_addr_i),
    .rd_wr_i     (rd_wr_i),
    .stall_o     (stall_o),
    .mem         (mem_bus),
    .reg_wr      (reg_wr),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .align_err   (align_err),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Writeback monitor: every reg_wr must match the head of the queue.
  always @(negedge clk) begin
    if (rst && reg_wr) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected_reg_wr", reg_wr, 0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("wb_addr", reg_addr, e[36:32]);
        check("wb_data", reg_data, e[31:0]);
      end
    end
  end

  // ---------------- reference helpers ----------------
  function automatic logic is_load(input logic [5:0] op);
    return op == LB || op == LH || op == LW || op == LBU || op == LHU;
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic [31:0] s;
    s = rdata >> (8 * off);
    case (op)
      LB:      return {{24{s[7]}}, s[7:0]};
      LBU:     return {24'h0, s[7:0]};
      LH:      return {{16{s[15]}}, s[15:0]};
      LHU:     return {16'h0, s[15:0]};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [5:0] op, input logic [1:0] off);
    case (op)
      LB, LBU, SB: return 4'b0001 << off;
      LH, LHU, SH: return 4'b0011 << off;
      default:     return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [5:0] op, input logic [31:0] wd);
    case (op)
      SB:      return {4{wd[7:0]}};
      SH:      return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_alu(input logic [31:0] data, input logic [4:0] rd);
    @(posedge clk); #1;
    valid_i = 1'b1; op_i = 6'h00; alu_data_i = data; rd_addr_i = rd; rd_wr_i = 1'b1;
    if (rd != 0) exp_q.push_back({rd, data});
    @(negedge clk);
    check("alu_stall", stall_o, 0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk); #1;
    check("alu_wb_drained", exp_q.size(), 0);
  endtask

  // exp_val: extended load data for loads, replicated store data for stores.
  task automatic do_mem(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int waits, input logic [4:0] rd,
                        input logic [3:0] exp_be, input logic [31:0] exp_val);
    int stalls;
    stalls = 0;
    @(posedge clk); #1;
    valid_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wd; rd_addr_i = rd; rd_wr_i = 1'b1;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = rdata;
    if (is_load(op) && rd != 0) exp_q.push_back({rd, exp_val});
    @(negedge clk);
    check("issue_ce_low", mem_bus.mem_ce, 0);
    if (stall_o) stalls++;
    for (int i = 0; i <= waits; i++) begin
      @(posedge clk); #1;
      mem_bus.mem_ready = (i == waits);
      @(negedge clk);
      check("acc_ce", mem_bus.mem_ce, 1);
      check("acc_addr", mem_bus.mem_addr, {addr[31:2], 2'b00});
      check("acc_be", mem_bus.mem_be, exp_be);
      check("acc_wr", mem_bus.mem_wr, !is_load(op));
      if (!is_load(op)) check("acc_wdata", mem_bus.mem_wdata, exp_val);
      check("acc_state", state_dbg, ACCESS);
      if (stall_o) stalls++;
    end
    @(posedge clk); #1;
    valid_i = 1'b0; mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    check("done_ce_low", mem_bus.mem_ce, 0);
    check("stall_cycles", stalls, waits + 1);
    #1;
    check("mem_wb_drained", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = '0;

    // Reset state, with an aligned lw presented to show stall is held low.
    valid_i = 1'b1; op_i = LW; addr_i = 32'h40; rd_addr_i = 5'd1; rd_wr_i = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_stall", stall_o, 0);
    check("rst_ce", mem_bus.mem_ce, 0);
    check("rst_reg_wr", reg_wr, 0);
    check("rst_reg_data", reg_data, 0);
    check("rst_align", align_err, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_state", state_dbg, IDLE);
    valid_i = 1'b0;
    rst = 1'b1;

    // Non-memory op.
    do_alu(32'h1234_5678, 5'd3);
    // Destination register 0 is never written.
    do_alu(32'hCAFE_F00D, 5'd0);

    // lb / lbu zero-wait at 0x103.
    do_mem(LB,  32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 5'd4, 4'b1000, 32'hFFFF_FF80);
    do_mem(LBU, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 5'd5, 4'b1000, 32'h0000_0080);

    // sh with 3 wait states.
    do_mem(SH, 32'h0000_0102, 32'hDEAD_BEEF, 32'h0, 3, 5'd6, 4'b1100, 32'hBEEF_BEEF);

    // Halfword load, signed, upper half.
    do_mem(LH, 32'h0000_0202, 32'h0, 32'h9ABC_1234, 1, 5'd7, 4'b1100, 32'hFFFF_9ABC);

    // Misaligned lw.
    @(posedge clk); #1;
    valid_i = 1'b1; op_i = LW; addr_i = 32'h0000_0101; rd_addr_i = 5'd8; rd_wr_i = 1'b1;
    @(negedge clk);
    check("misalign_stall", stall_o, 0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    check("misalign_pulse", align_err, 1);
    check("misalign_ce", mem_bus.mem_ce, 0);
    check("misalign_reg_wr", reg_wr, 0);
    @(negedge clk);
    check("misalign_pulse_end", align_err, 0);

    // Timeout: mem_ready stays 0.
    @(posedge clk); #1;
    valid_i = 1'b1; op_i = LW; addr_i = 32'h0000_0300; rd_addr_i = 5'd9; rd_wr_i = 1'b1;
    mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    check("tmo_issue_stall", stall_o, 1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("tmo_ce_held", mem_bus.mem_ce, 1);
      check("tmo_no_pulse", timeout_err, 0);
      check("tmo_stall", stall_o, (i < 15));
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    check("tmo_pulse", timeout_err, 1);
    check("tmo_ce_drop", mem_bus.mem_ce, 0);
    check("tmo_state", state_dbg, IDLE);
    check("tmo_reg_wr", reg_wr, 0);
    do_alu(32'h0BAD_F00D, 5'd10);

    // Reset during the 2nd wait cycle of a load.
    @(posedge clk); #1;
    valid_i = 1'b1; op_i = LB; addr_i = 32'h0000_0104; rd_addr_i = 5'd11; rd_wr_i = 1'b1;
    mem_bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("pre_rst_ce", mem_bus.mem_ce, 1);
    rst = 1'b0;
    #1;
    check("async_rst_ce", mem_bus.mem_ce, 0);
    check("async_rst_stall", stall_o, 0);
    check("async_rst_reg_wr", reg_wr, 0);
    check("async_rst_state", state_dbg, IDLE);
    valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_mem(LW, 32'h0000_0400, 32'h0, 32'h1357_9BDF, 0, 5'd12, 4'b1111, 32'h1357_9BDF);

    // Randomised mix of ALU ops, loads and stores.
    for (int n = 0; n < 24; n++) begin
      int kind;
      logic [5:0]  op;
      logic [1:0]  off;
      logic [31:0] a, d;
      logic [4:0]  rd;
      kind = $urandom_range(0, 2);
      d    = $urandom;
      rd   = 5'($urandom_range(0, 31));
      if (kind == 0) begin
        do_alu(d, rd);
      end else begin
        case ($urandom_range(0, 7))
          0: op = LB;  1: op = LBU; 2: op = LH; 3: op = LHU;
          4: op = LW;  5: op = SB;  6: op = SH; default: op = SW;
        endcase
        case (op)
          LB, LBU, SB: off = 2'($urandom_range(0, 3));
          LH, LHU, SH: off = {1'($urandom_range(0, 1)), 1'b0};
          default:     off = 2'b00;
        endcase
        a = {18'h0, 12'($urandom_range(0, 4095)), off};
        do_mem(op, a, d, ~d ^ 32'h5A5A_0F0F, $urandom_range(0, 4), rd, ref_be(op, off),
               is_load(op) ? ref_load(op, off, ~d ^ 32'h5A5A_0F0F) : ref_store(op, d));
      end
    end

    repeat (2) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
